// File: rtl/fringe_gen_4steps_pkg.sv
// Shared types and constants for the 4-step fringe generator: the 8-bit sine
// table, the 90-degree phase offset between frames and the sequencer states.
package fringe_pkg;

  localparam logic [15:0] QUARTER_PHASE = 16'h4000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fringe_state_e;

  // One full sine period over 256 entries, offset-binary around 128.
  localparam logic [7:0] SIN_LUT [256] = '{
    8'h80, 8'h83, 8'h86, 8'h89, 8'h8C, 8'h8F, 8'h92, 8'h95, 8'h98, 8'h9B, 8'h9E, 8'hA2, 8'hA5, 8'hA7, 8'hAA, 8'hAD,
    8'hB0, 8'hB3, 8'hB6, 8'hB9, 8'hBC, 8'hBE, 8'hC1, 8'hC4, 8'hC6, 8'hC9, 8'hCB, 8'hCE, 8'hD0, 8'hD3, 8'hD5, 8'hD7,
    8'hDA, 8'hDC, 8'hDE, 8'hE0, 8'hE2, 8'hE4, 8'hE6, 8'hE8, 8'hEA, 8'hEB, 8'hED, 8'hEE, 8'hF0, 8'hF1, 8'hF3, 8'hF4,
    8'hF5, 8'hF6, 8'hF8, 8'hF9, 8'hFA, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFD, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFF,
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFD, 8'hFD, 8'hFC, 8'hFB, 8'hFA, 8'hFA, 8'hF9, 8'hF8, 8'hF6,
    8'hF5, 8'hF4, 8'hF3, 8'hF1, 8'hF0, 8'hEE, 8'hED, 8'hEB, 8'hEA, 8'hE8, 8'hE6, 8'hE4, 8'hE2, 8'hE0, 8'hDE, 8'hDC,
    8'hDA, 8'hD7, 8'hD5, 8'hD3, 8'hD0, 8'hCE, 8'hCB, 8'hC9, 8'hC6, 8'hC4, 8'hC1, 8'hBE, 8'hBC, 8'hB9, 8'hB6, 8'hB3,
    8'hB0, 8'hAD, 8'hAA, 8'hA7, 8'hA5, 8'hA2, 8'h9E, 8'h9B, 8'h98, 8'h95, 8'h92, 8'h8F, 8'h8C, 8'h89, 8'h86, 8'h83,
    8'h80, 8'h7C, 8'h79, 8'h76, 8'h73, 8'h70, 8'h6D, 8'h6A, 8'h67, 8'h64, 8'h61, 8'h5D, 8'h5A, 8'h58, 8'h55, 8'h52,
    8'h4F, 8'h4C, 8'h49, 8'h46, 8'h43, 8'h41, 8'h3E, 8'h3B, 8'h39, 8'h36, 8'h34, 8'h31, 8'h2F, 8'h2C, 8'h2A, 8'h28,
    8'h25, 8'h23, 8'h21, 8'h1F, 8'h1D, 8'h1B, 8'h19, 8'h17, 8'h15, 8'h14, 8'h12, 8'h11, 8'h0F, 8'h0E, 8'h0C, 8'h0B,
    8'h0A, 8'h09, 8'h07, 8'h06, 8'h05, 8'h05, 8'h04, 8'h03, 8'h02, 8'h02, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h04, 8'h05, 8'h05, 8'h06, 8'h07, 8'h09,
    8'h0A, 8'h0B, 8'h0C, 8'h0E, 8'h0F, 8'h11, 8'h12, 8'h14, 8'h15, 8'h17, 8'h19, 8'h1B, 8'h1D, 8'h1F, 8'h21, 8'h23,
    8'h25, 8'h28, 8'h2A, 8'h2C, 8'h2F, 8'h31, 8'h34, 8'h36, 8'h39, 8'h3B, 8'h3E, 8'h41, 8'h43, 8'h46, 8'h49, 8'h4C,
    8'h4F, 8'h52, 8'h55, 8'h58, 8'h5A, 8'h5D, 8'h61, 8'h64, 8'h67, 8'h6A, 8'h6D, 8'h70, 8'h73, 8'h76, 8'h79, 8'h7C
  };

  // Phase of column 0 for a given frame, relative to init_phase.
  function automatic logic [15:0] frame_offset(input logic [1:0] frame);
    return {frame, 14'h0000};
  endfunction

endpackage

// File: rtl/fringe_gen_4steps_if.sv
// AXI4-Stream beat channel carrying 2*PIPE_NUM 8-bit pixels per beat.
interface fringe_gen_4steps_if #(
  parameter int PIPE_NUM = 8
) ();
  logic [PIPE_NUM*16-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fringe_gen_4steps_pix_calc.sv
// Combinational beat builder: pixel n of the beat takes the sine of
// (base + n*inc), using the top 8 phase bits as the table index.
module fringe_pix_calc
  import fringe_pkg::*;
#(
  parameter int PIPE_NUM = 8
) (
  input  logic [15:0]             base_i,
  input  logic [15:0]             inc_i,
  output logic [PIPE_NUM*16-1:0]  beat_o
);

  logic [15:0] ph_s;

  // Per-pixel phase and table lookup.
  always_comb begin
    beat_o = {(PIPE_NUM*16){1'b0}};
    ph_s   = base_i;
    for (int n = 0; n < 2*PIPE_NUM; n++) begin
      ph_s = base_i + 16'(n * inc_i);
      beat_o[8*n +: 8] = SIN_LUT[ph_s[15:8]];
    end
  end

endmodule

// File: rtl/fringe_gen_4steps.sv
// 4-step phase-shifted fringe generator streaming 4 frames over AXI4-Stream.
// Optional FRINGE_SEQ_CNT_EN adds a completed-sequence counter output.
module fringe_gen_4steps
  import fringe_pkg::*;
#(
  parameter int PIPE_NUM   = 8,
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 1024
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  input  logic [15:0]         phase_inc,
  input  logic [15:0]         init_phase,
  output logic                busy,
  output logic                done,
  fringe_gen_4steps_if.master m_axis
`ifdef FRINGE_SEQ_CNT_EN
  ,
  output logic [15:0]         seq_cnt
`endif
);

  localparam int BEAT_W       = PIPE_NUM * 16;
  localparam int PIX_PER_BEAT = 2 * PIPE_NUM;
  localparam int COL_W        = $clog2(IMG_WIDTH + 1);
  localparam int ROW_W        = $clog2(IMG_HEIGHT + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - PIX_PER_BEAT);
  localparam logic [COL_W-1:0] COL_STEP = COL_W'(PIX_PER_BEAT);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [15:0]      PIX_MUL  = 16'(PIX_PER_BEAT);

  fringe_state_e     state_q;
  logic [1:0]        frame_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [15:0]       base_q;
  logic [15:0]       inc_q;
  logic [15:0]       init_q;
  logic [15:0]       step_q;
  logic              gen_left_q;
  logic [BEAT_W-1:0] tdata_q;
  logic              tvalid_q;
  logic              tlast_q;
  logic              busy_q;
  logic              done_q;

  logic [1:0]        frame_d;
  logic [ROW_W-1:0]  row_d;
  logic [COL_W-1:0]  col_d;
  logic [15:0]       base_d;

  logic [BEAT_W-1:0] pix_s;
  logic              col_end_s;
  logic              row_end_s;
  logic              beat_last_s;
  logic              seq_last_s;
  logic              load_s;
  logic              final_hs_s;

  fringe_pix_calc #(.PIPE_NUM(PIPE_NUM)) u_pix_calc (
    .base_i (base_q),
    .inc_i  (inc_q),
    .beat_o (pix_s)
  );

  // The counters point at the beat about to enter the output register.
  assign col_end_s   = (col_q == COL_LAST);
  assign row_end_s   = (row_q == ROW_LAST);
  assign beat_last_s = col_end_s & row_end_s;
  assign seq_last_s  = beat_last_s & (frame_q == 2'd3);
  assign load_s      = ~tvalid_q | m_axis.tready;
  assign final_hs_s  = (state_q == RUN) & tvalid_q & m_axis.tready & ~gen_left_q;

  // Next column/row/frame position and phase base for the following beat.
  always_comb begin
    col_d   = col_q + COL_STEP;
    row_d   = row_q;
    frame_d = frame_q;
    base_d  = base_q + step_q;
    if (col_end_s) begin
      col_d = {COL_W{1'b0}};
      if (row_end_s) begin
        row_d   = {ROW_W{1'b0}};
        frame_d = frame_q + 2'd1;
      end else begin
        row_d   = row_q + ROW_W'(1);
        frame_d = frame_q;
      end
      base_d = init_q + frame_offset(frame_d);
    end else begin
      col_d = col_q + COL_STEP;
    end
  end

  // Sequencer FSM, beat counters and the output register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      frame_q    <= 2'd0;
      row_q      <= {ROW_W{1'b0}};
      col_q      <= {COL_W{1'b0}};
      base_q     <= 16'h0000;
      inc_q      <= 16'h0000;
      init_q     <= 16'h0000;
      step_q     <= 16'h0000;
      gen_left_q <= 1'b0;
      tdata_q    <= {BEAT_W{1'b0}};
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            inc_q      <= phase_inc;
            init_q     <= init_phase;
            step_q     <= phase_inc * PIX_MUL;
            base_q     <= init_phase;
            frame_q    <= 2'd0;
            row_q      <= {ROW_W{1'b0}};
            col_q      <= {COL_W{1'b0}};
            gen_left_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (load_s) begin
            if (gen_left_q) begin
              tdata_q    <= pix_s;
              tlast_q    <= beat_last_s;
              tvalid_q   <= 1'b1;
              col_q      <= col_d;
              row_q      <= row_d;
              frame_q    <= frame_d;
              base_q     <= base_d;
              gen_left_q <= ~seq_last_s;
            end else begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
            end
          end else begin
            tvalid_q <= tvalid_q;
          end
          if (final_hs_s) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= RUN;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          gen_left_q <= 1'b0;
          tvalid_q   <= 1'b0;
          tlast_q    <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef FRINGE_SEQ_CNT_EN
  logic [15:0] seq_cnt_q;

  // Completed-sequence counter, visible in the DONE cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      seq_cnt_q <= 16'd0;
    end else if (final_hs_s) begin
      seq_cnt_q <= seq_cnt_q + 16'd1;
    end else begin
      seq_cnt_q <= seq_cnt_q;
    end
  end

  assign seq_cnt = seq_cnt_q;
`endif

endmodule

// File: tb/tb_fringe_gen_4steps.sv
// Randomised self-checking bench for fringe_gen_4steps against a direct
// formula model of the fringe pixels (PIPE_NUM=2, 8x2 image).
module tb_fringe_gen_4steps;

  localparam int P           = 2;
  localparam int W           = 8;
  localparam int H           = 2;
  localparam int PIX         = 2 * P;
  localparam int BEATS_ROW   = W / PIX;
  localparam int BEATS_FRAME = BEATS_ROW * H;
  localparam int SEQ_BEATS   = 4 * BEATS_FRAME;
  localparam real PI_R       = 3.14159265358979323846;

  logic        aclk;
  logic        aresetn;
  logic        start;
  logic [15:0] phase_inc;
  logic [15:0] init_phase;
  logic        busy;
  logic        done;
`ifdef FRINGE_SEQ_CNT_EN
  logic [15:0] seq_cnt;
`endif

  fringe_gen_4steps_if #(.PIPE_NUM(P)) axis ();

  fringe_gen_4steps #(.PIPE_NUM(P), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .start      (start),
    .phase_inc  (phase_inc),
    .init_phase (init_phase),
    .busy       (busy),
    .done       (done),
    .m_axis     (axis)
`ifdef FRINGE_SEQ_CNT_EN
    ,
    .seq_cnt    (seq_cnt)
`endif
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_seq = 0;
  logic [7:0]  ref_lut [256];
  logic [31:0] beat_q [$];
  bit          last_q [$];
  int          done_cnt = 0;
  int          cyc_cnt = 0;
  int          last_hs_cyc = 0;
  int          done_cyc = 0;
  bit          hold_pending = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pixel value straight from the definition: sine of the absolute column phase.
  function automatic logic [31:0] model_beat(input int init, input int inc, input int b);
    int f;
    int col0;
    int p;
    logic [31:0] r;
    f    = b / BEATS_FRAME;
    col0 = ((b % BEATS_FRAME) % BEATS_ROW) * PIX;
    r    = 32'h0;
    for (int n = 0; n < PIX; n++) begin
      p = (init + (col0 + n) * inc + f * 16384) & 65535;
      r[8*n +: 8] = ref_lut[p >> 8];
    end
    return r;
  endfunction

  function automatic bit model_last(input int b);
    return (b % BEATS_FRAME) == (BEATS_FRAME - 1);
  endfunction

  // Handshake capture, stall-stability checking and done-pulse counting.
  always @(negedge aclk) begin
    cyc_cnt++;
    if (!aresetn) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check_val("stall_tvalid", axis.tvalid, 1'b1);
        check_val("stall_tdata", axis.tdata, hold_data);
        check_val("stall_tlast", axis.tlast, hold_last);
      end
      if (axis.tvalid && axis.tready) begin
        beat_q.push_back(axis.tdata);
        last_q.push_back(axis.tlast);
        last_hs_cyc = cyc_cnt;
      end
      hold_pending = axis.tvalid && !axis.tready;
      hold_data    = axis.tdata;
      hold_last    = axis.tlast;
      if (done) begin
        done_cnt++;
        done_cyc = cyc_cnt;
      end
    end
  end

  task automatic run_seq(input logic [15:0] inc, input logic [15:0] init, input bit rand_ready,
                         input bit mid_start, input bit start_in_done, input int abort_at);
    bit finished;
    finished = 1'b0;
    beat_q.delete();
    last_q.delete();
    done_cnt = 0;
    axis.tready = 1'b1;
    @(posedge aclk); #1;
    start = 1'b1;
    phase_inc = inc;
    init_phase = init;
    @(posedge aclk); #1;
    start = 1'b0;
    check_val("busy_set", busy, 1'b1);
    phase_inc = 16'($urandom);
    init_phase = 16'($urandom);
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mid_start && cyc == 3) begin
        start = 1'b1;
        init_phase = 16'h8000;
      end else begin
        start = 1'b0;
      end
      if (abort_at > 0 && beat_q.size() >= abort_at) begin
        aresetn = 1'b0;
        #1;
        check_val("abort_tvalid", axis.tvalid, 1'b0);
        check_val("abort_busy", busy, 1'b0);
        exp_seq = 0;
        @(posedge aclk); #3;
        aresetn = 1'b1;
        return;
      end
      if (done) begin
        if (start_in_done) start = 1'b1;
        finished = 1'b1;
      end
      @(posedge aclk); #1;
    end
    start = 1'b0;
    axis.tready = 1'b1;
    repeat (4) begin
      @(posedge aclk); #1;
    end
    check_val("no_timeout", finished, 1'b1);
    check_val("done_count", done_cnt, 1);
    check_val("done_latency", done_cyc - last_hs_cyc, 1);
    check_val("busy_after", busy, 1'b0);
    check_val("tvalid_after", axis.tvalid, 1'b0);
    check_val("beat_count", beat_q.size(), SEQ_BEATS);
    for (int b = 0; b < beat_q.size() && b < SEQ_BEATS; b++) begin
      check_val($sformatf("tdata[%0d]", b), beat_q[b], model_beat(int'(init), int'(inc), b));
      check_val($sformatf("tlast[%0d]", b), last_q[b], model_last(b));
    end
    exp_seq++;
`ifdef FRINGE_SEQ_CNT_EN
    check_val("seq_cnt", seq_cnt, exp_seq);
`endif
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      ref_lut[k] = 8'($rtoi($floor(127.5 + 127.5 * $sin(2.0 * PI_R * k / 256.0) + 0.5)));
    end
    aresetn = 1'b0;
    start = 1'b0;
    phase_inc = 16'h0;
    init_phase = 16'h0;
    axis.tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_tvalid", axis.tvalid, 1'b0);
    check_val("rst_tlast", axis.tlast, 1'b0);
    check_val("rst_tdata", axis.tdata, 32'h0);
`ifdef FRINGE_SEQ_CNT_EN
    check_val("rst_seq_cnt", seq_cnt, 16'd0);
`endif
    #2 aresetn = 1'b1;
    repeat (2) @(posedge aclk);

    // Basic run, plus a start landing in the DONE cycle
    run_seq(16'h2000, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
    check_val("s1_f0b0", (beat_q.size() > 0) ? beat_q[0] : 32'h0, 32'hDAFFDA80);
    check_val("s1_f0b1", (beat_q.size() > 1) ? beat_q[1] : 32'h0, 32'h25002580);
    check_val("s1_f1b0", (beat_q.size() > 4) ? beat_q[4] : 32'h0, 32'h2580DAFF);

    // Random back-pressure
    run_seq(16'h2000, 16'h0000, 1'b1, 1'b0, 1'b0, 0);

    // Reset in the middle, then restart
    run_seq(16'h2000, 16'h0000, 1'b0, 1'b0, 1'b0, 6);
    run_seq(16'h2000, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
    check_val("s4_restart_b0", (beat_q.size() > 0) ? beat_q[0] : 32'h0, 32'hDAFFDA80);

    // Start during RUN is ignored
    run_seq(16'h2000, 16'h0000, 1'b0, 1'b1, 1'b0, 0);

    // Constant phase per frame
    run_seq(16'h0000, 16'hC000, 1'b1, 1'b0, 1'b0, 0);
    check_val("s6_f0", (beat_q.size() > 0) ? beat_q[0] : 32'h1, 32'h00000000);
    check_val("s6_f1", (beat_q.size() > 4) ? beat_q[4] : 32'h1, 32'h80808080);
    check_val("s6_f2", (beat_q.size() > 8) ? beat_q[8] : 32'h1, 32'hFFFFFFFF);
    check_val("s6_f3", (beat_q.size() > 12) ? beat_q[12] : 32'h1, 32'h80808080);

    // Random phase settings
    repeat (4) begin
      run_seq(16'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
